// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and counter sizing.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Bits needed to hold a shift count in the range 0..width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/usr_word_counter.sv
// Word counter: tracks consecutive same-direction shifts and pulses word_valid
// once a full word of WIDTH shifts has been accumulated.
module usr_word_counter
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  output logic [cnt_w(WIDTH)-1:0]   shift_cnt,
  output logic                      word_valid
);

  localparam int unsigned CW = cnt_w(WIDTH);

  mode_e           w_mode;
  logic            w_is_shift;
  logic            w_dir_left;
  logic [CW-1:0]   w_cnt_inc;
  logic [CW-1:0]   w_cnt_next;
  logic            w_dir_next;
  logic            w_wv_next;
  logic [CW-1:0]   r_cnt;
  logic            r_dir;
  logic            r_wv;

  assign w_mode     = mode_e'(mode);
  assign w_is_shift = en && ((w_mode == MODE_SHR) || (w_mode == MODE_SHL));
  assign w_dir_left = (w_mode == MODE_SHL);
  // A count of zero (after reset, load or wrap) makes either direction start at 1.
  assign w_cnt_inc  = (w_dir_left == r_dir) ? r_cnt + CW'(1) : CW'(1);

  // Next-state for count, direction and the word pulse.
  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir;
    w_wv_next  = 1'b0;
    if (en && (w_mode == MODE_LOAD)) begin
      w_cnt_next = '0;
    end else if (w_is_shift) begin
      w_dir_next = w_dir_left;
      if (w_cnt_inc == CW'(WIDTH)) begin
        w_cnt_next = '0;
        w_wv_next  = 1'b1;
      end else begin
        w_cnt_next = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dir <= 1'b0;
      r_wv  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_dir <= w_dir_next;
      r_wv  <= w_wv_next;
    end
  end

  assign shift_cnt  = r_cnt;
  assign word_valid = r_wv;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift right/left (serial or rotate), parallel load,
// with word-completion tracking in usr_word_counter.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ROTATE = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic                     serial_in_r,
  input  logic                     serial_in_l,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic                     serial_out_r,
  output logic                     serial_out_l,
  output logic [cnt_w(WIDTH)-1:0]  shift_cnt,
  output logic                     word_valid
);

  mode_e             w_mode;
  logic              w_in_msb;
  logic              w_in_lsb;
  logic [WIDTH-1:0]  w_q_next;
  logic [WIDTH-1:0]  r_q;

  assign w_mode   = mode_e'(mode);
  assign w_in_msb = (ROTATE != 0) ? r_q[0]       : serial_in_r;
  assign w_in_lsb = (ROTATE != 0) ? r_q[WIDTH-1] : serial_in_l;

  // Data path next-state.
  always_comb begin
    w_q_next = r_q;
    if (en) begin
      case (w_mode)
        MODE_SHR:  w_q_next = {w_in_msb, r_q[WIDTH-1:1]};
        MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], w_in_lsb};
        MODE_LOAD: w_q_next = d;
        default:   w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  usr_word_counter #(.WIDTH(WIDTH)) u_word_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .shift_cnt  (shift_cnt),
    .word_valid (word_valid)
  );

  assign q            = r_q;
  assign serial_out_r = r_q[0];
  assign serial_out_l = r_q[WIDTH-1];

endmodule
